booth_div: RTL and testbench

- Sequential signed divider, the inverse companion to the Booth multiplier in the arithmetic datapath.
- Divides a 2W-bit dividend by a W-bit divisor using radix-2 restoring steps on magnitudes.
- Returns a W-bit quotient and a W-bit remainder.
- Uses the same level-enable / done handshake as the multiplier, so a controller can drive both blocks alike.

---
 rtl/booth_div_if.sv | 24 ++
 rtl/booth_div.sv | 110 +++++++++++
 tb/tb_booth_div.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_div_if.sv
// Level-enable / done handshake bundle for the sequential signed divider.
// Same shape as the multiplier bus so one controller can drive either.
interface booth_div_if #(
  parameter int W = 16
);
  logic           en;
  logic [2*W-1:0] A;
  logic [W-1:0]   B;
  logic [W-1:0]   Quot;
  logic [W-1:0]   Rem;
  logic           done;
  logic           dbz;
  logic           ovf;

  modport master (
    output en, A, B,
    input  Quot, Rem, done, dbz, ovf
  );

  modport slave (
    input  en, A, B,
    output Quot, Rem, done, dbz, ovf
  );
endinterface

// File: rtl/booth_div.sv
// Sequential signed 2W/W divider: radix-2 restoring steps on magnitudes,
// quotient truncated toward zero, remainder takes the dividend's sign.
module booth_div #(
  parameter int W = 16
) (
  input logic       clk,
  input logic       rst_n,
  booth_div_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   r, q, bm;
  logic           sq, sr, dz, oh;
  logic [W-1:0]   quot, rem;
  logic           dbz, ovf;

  logic [2*W-1:0] am;
  logic [W-1:0]   bmag;
  logic [W:0]     rs, df;
  logic           qovf, bad;
  logic [W-1:0]   qs, rsg;

  // An unsigned 2W-bit magnitude holds 2^(2W-1) exactly, so the most
  // negative dividend needs no extra handling here.
  always_comb begin
    am   = bus.A[2*W-1] ? -bus.A : bus.A;
    bmag = bus.B[W-1] ? -bus.B : bus.B;
    rs   = {r, q[W-1]};
    df   = rs - {1'b0, bm};
    qovf = sq ? (q > {1'b1, {(W-1){1'b0}}})
              : q[W-1];
    bad  = dz | oh | qovf;
    qs   = sq ? -q : q;
    rsg  = sr ? -r : r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.en) nxt = CALC;
      CALC: begin
        if (!bus.en)         nxt = IDLE;
        else if (cnt == '0)  nxt = FIX;
      end
      FIX:  nxt = bus.en ? DONE : IDLE;
      DONE: if (!bus.en) nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      r    <= '0;
      q    <= '0;
      bm   <= '0;
      sq   <= 1'b0;
      sr   <= 1'b0;
      dz   <= 1'b0;
      oh   <= 1'b0;
      quot <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE && bus.en) begin
      r   <= am[2*W-1:W];
      q   <= am[W-1:0];
      bm  <= bmag;
      sq  <= bus.A[2*W-1] ^ bus.B[W-1];
      sr  <= bus.A[2*W-1];
      dz  <= (bus.B == '0);
      oh  <= (am[2*W-1:W] >= bmag);
      cnt <= CW'(W);
    end else if (state == CALC && cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (!df[W]) begin
        r <= df[W-1:0];
        q <= {q[W-2:0], 1'b1};
      end else begin
        r <= rs[W-1:0];
        q <= {q[W-2:0], 1'b0};
      end
    end else if (state == FIX && bus.en) begin
      dbz  <= dz;
      ovf  <= ~dz & (oh | qovf);
      quot <= bad ? '0 : qs;
      rem  <= bad ? '0 : rsg;
    end
  end

  assign bus.Quot = quot;
  assign bus.Rem  = rem;
  assign bus.dbz  = dbz;
  assign bus.ovf  = ovf;
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_booth_div.sv
// Directed and constrained-random bench for booth_div against an
// arithmetic truncating-division model.
module tb_booth_div;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_div_if #(.W(W)) bif ();

  booth_div #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  int nvec = 0;
  int nmis = 0;

  logic [15:0] exp_q, exp_r;
  logic        exp_d, exp_o;
  logic [31:0] cur_a;
  logic [15:0] cur_b;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic ed, output logic eo);
    longint sa, sb, qt, rt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eq = '0;
    er = '0;
    ed = 1'b0;
    eo = 1'b0;
    if (sb == 0) begin
      ed = 1'b1;
    end else begin
      qt = sa / sb;
      rt = sa % sb;
      if (qt > 32767 || qt < -32768) eo = 1'b1;
      else begin
        eq = 16'(qt);
        er = 16'(rt);
      end
    end
  endtask

  // Every cycle the result is valid it must match the model.
  always @(negedge clk) begin
    if (bif.done) begin
      chk("quot", 64'(bif.Quot), 64'(exp_q));
      chk("rem",  64'(bif.Rem),  64'(exp_r));
      chk("dbz",  64'(bif.dbz),  64'(exp_d));
      chk("ovf",  64'(bif.ovf),  64'(exp_o));
      if (!exp_d && !exp_o) begin
        chk("ident",
            64'(longint'($signed(bif.Quot)) * longint'($signed(cur_b))
                + longint'($signed(bif.Rem))),
            64'(longint'($signed(cur_a))));
        chk("remlt",
            64'(labs(longint'($signed(bif.Rem)))
                < labs(longint'($signed(cur_b)))), 64'(1));
        chk("rsign",
            64'(bif.Rem == 16'h0 || bif.Rem[15] == cur_a[31]), 64'(1));
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [15:0] b);
    int n;
    bit got;
    model(a, b, exp_q, exp_r, exp_d, exp_o);
    cur_a = a;
    cur_b = b;
    @(negedge clk);
    bif.A  = a;
    bif.B  = b;
    bif.en = 1'b1;
    @(posedge clk);
    #1;
    bif.A = ~a;
    bif.B = ~b;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (bif.done) got = 1'b1;
    end
    chk("latency", 64'(n), 64'(18));
    repeat (3) @(negedge clk);
    @(negedge clk);
    bif.en = 1'b0;
    @(posedge clk);
    #1;
    chk("done_drop", 64'(bif.done), 64'(0));
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [15:0] q,
                     input logic [15:0] r, input logic d, input logic o);
    chk({nm, "_q"}, 64'(bif.Quot), 64'(q));
    chk({nm, "_r"}, 64'(bif.Rem),  64'(r));
    chk({nm, "_d"}, 64'(bif.dbz),  64'(d));
    chk({nm, "_o"}, 64'(bif.ovf),  64'(o));
  endtask

  initial begin
    int dn;
    bif.en = 1'b0;
    bif.A  = '0;
    bif.B  = '0;
    exp_q  = '0;
    exp_r  = '0;
    exp_d  = 1'b0;
    exp_o  = 1'b0;
    cur_a  = '0;
    cur_b  = 16'd1;
    #3;
    chk("rst_quot", 64'(bif.Quot), 64'(0));
    chk("rst_rem",  64'(bif.Rem),  64'(0));
    chk("rst_done", 64'(bif.done), 64'(0));
    chk("rst_dbz",  64'(bif.dbz),  64'(0));
    chk("rst_ovf",  64'(bif.ovf),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 16'd7);
    lit("t1", 16'h000E, 16'h0002, 1'b0, 1'b0);
    run_op(32'hFFFFFF9C, 16'd7);
    lit("neg_a", 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
    run_op(32'd100, 16'hFFF9);
    lit("neg_b", 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    run_op(32'hFFFFFF9C, 16'hFFF9);
    lit("neg_ab", 16'h000E, 16'hFFFE, 1'b0, 1'b0);

    run_op(32'hFFFF8000, 16'd1);
    lit("minq", 16'h8000, 16'h0000, 1'b0, 1'b0);
    run_op(32'h00008000, 16'd1);
    lit("posovf", 16'h0, 16'h0, 1'b0, 1'b1);
    run_op(32'h00080000, 16'd2);
    lit("hiovf", 16'h0, 16'h0, 1'b0, 1'b1);
    run_op(32'h80000000, 16'hFFFF);
    lit("minovf", 16'h0, 16'h0, 1'b0, 1'b1);

    run_op(32'h12345678, 16'd0);
    lit("dbz", 16'h0, 16'h0, 1'b1, 1'b0);
    run_op(32'd50, 16'd5);
    lit("after_dbz", 16'd10, 16'd0, 1'b0, 1'b0);

    // Abort by dropping en mid-iteration.
    @(negedge clk);
    bif.A  = 32'd100;
    bif.B  = 16'd7;
    bif.en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bif.en = 1'b0;
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (bif.done) dn++;
    end
    chk("abort_done", 64'(dn), 64'(0));
    lit("abort_hold", 16'd10, 16'd0, 1'b0, 1'b0);
    run_op(32'd100, 16'd7);
    lit("rerun", 16'h000E, 16'h0002, 1'b0, 1'b0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    bif.A  = 32'd1000;
    bif.B  = 16'd3;
    bif.en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_quot", 64'(bif.Quot), 64'(0));
    chk("arst_rem",  64'(bif.Rem),  64'(0));
    chk("arst_done", 64'(bif.done), 64'(0));
    chk("arst_dbz",  64'(bif.dbz),  64'(0));
    chk("arst_ovf",  64'(bif.ovf),  64'(0));
    @(negedge clk);
    bif.en = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] b16;
      longint qi, lb, rv, a0;
      b16 = 16'($urandom);
      if (b16 == 16'h0) b16 = 16'd1;
      lb = longint'($signed(b16));
      qi = longint'($signed(16'($urandom)));
      rv = longint'($urandom) % labs(lb);
      a0 = qi * lb;
      if (a0 < 0 || (a0 == 0 && $urandom_range(1, 0) == 1)) rv = -rv;
      run_op(32'(a0 + rv), b16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
